// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU (alu_seq) and its multiplier.
//   - Opcode map (OP_AND ... OP_NOT). Any code not listed here is illegal.
//   - FSM state encoding for the alu_seq controller.
//   - Packed flag bundle {cr, ov, ng, zr}.
// Optional multiplier support is selected with the ALU_SEQ_MUL_EN macro.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LS  = 4'b0011;
    localparam logic [3:0] OP_SRS = 4'b0100;
    localparam logic [3:0] OP_URS = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_RRO = 4'b1000;
    localparam logic [3:0] OP_LRO = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic cr;
        logic ov;
        logic ng;
        logic zr;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier used by alu_seq when ALU_SEQ_MUL_EN
// is defined.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse; a and b are captured on this edge
//   a, b                  multiplicand, multiplier (WIDTH bits, unsigned)
//   done                  high for exactly one cycle when the product is ready
//   product_hi/product_lo upper/lower WIDTH bits of a*b
// The first shift-add step is folded into the start edge, so the product is
// complete WIDTH-1 cycles later and done is seen in cycle WIDTH after start.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic             busy;

    // One step: conditionally add the multiplicand into the upper half, then
    // shift the whole {acc_hi, mplier} pair right by one.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] mpl,
                                                input logic [WIDTH-1:0] mc);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc} + (mpl[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        return {sum, mpl[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand            <= a;
            {acc_hi, mplier} <= step('0, b, a);
            count            <= CNT_W'(WIDTH - 1);
            busy             <= 1'b1;
        end else if (busy) begin
            if (count != '0) begin
                {acc_hi, mplier} <= step(acc_hi, mplier, mcand);
                count            <= count - 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done       = busy && (count == '0);
    assign product_hi = acc_hi;
    assign product_lo = mplier;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a valid/ready handshake.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake; in_ready is high only in IDLE
//   op, ina, inb       opcode and operands
//   shamt              shift/rotate amount
//   out_valid/out_ready result handshake; outputs are held while out_valid
//   result, result_hi  result (result_hi is the MUL upper half, else 0)
//   cr, ov, ng, zr     carry, signed overflow, negative, zero
//   illegal            opcode not supported
// Macro ALU_SEQ_MUL_EN: when defined, MUL runs on the iterative multiplier
// (out_valid WIDTH+1 cycles after acceptance); when undefined MUL is an
// illegal opcode and result_hi is constant 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               cr,
    output logic               ov,
    output logic               ng,
    output logic               zr,
    output logic               illegal
);

    state_t           state, state_next;
    logic [WIDTH-1:0] res_reg;
    flags_t           flags_reg;
    logic             illegal_reg;
    logic             load_alu;

    // Single-cycle datapath, evaluated straight from the request inputs so
    // the result can be registered on the acceptance edge.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [31:0]      sh;
    logic [31:0]      rot;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic             alu_illegal;

    assign is_sub  = (op == OP_SUB);
    assign b_eff   = inb ^ {WIDTH{is_sub}};
    assign sum_ext = {1'b0, ina} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sh      = 32'(shamt);
    assign rot     = sh % 32'(WIDTH);

    always_comb begin
        alu_res     = '0;
        alu_flags   = '0;
        alu_illegal = 1'b0;
        case (op)
            OP_AND: alu_res = ina & inb;
            OP_OR:  alu_res = ina | inb;
            OP_ADD, OP_SUB: begin
                alu_res      = sum_ext[WIDTH-1:0];
                alu_flags.cr = sum_ext[WIDTH];
                // Overflow: both addends share a sign that the sum lacks.
                alu_flags.ov = (ina[WIDTH-1] == b_eff[WIDTH-1]) &&
                               (sum_ext[WIDTH-1] != ina[WIDTH-1]);
            end
            OP_LS:  alu_res = (sh >= 32'(WIDTH)) ? '0 : (ina << sh);
            OP_URS: alu_res = (sh >= 32'(WIDTH)) ? '0 : (ina >> sh);
            OP_SRS: alu_res = (sh >= 32'(WIDTH)) ? {WIDTH{ina[WIDTH-1]}}
                                                 : $unsigned($signed(ina) >>> sh);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (ina < inb)};
            // A rotate by 0 shifts the other term by WIDTH, which yields 0.
            OP_RRO: alu_res = (ina >> rot) | (ina << (32'(WIDTH) - rot));
            OP_LRO: alu_res = (ina << rot) | (ina >> (32'(WIDTH) - rot));
            OP_NOT: alu_res = ~ina;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: alu_res = '0;
`endif
            default: alu_illegal = 1'b1;
        endcase
        alu_flags.ng = alu_res[WIDTH-1];
        alu_flags.zr = (alu_res == '0);
    end

`ifdef ALU_SEQ_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic             load_mul;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] res_hi_reg;
    flags_t           mul_flags;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mul_start),
        .a          (ina),
        .b          (inb),
        .done       (mul_done),
        .product_hi (mul_hi),
        .product_lo (mul_lo)
    );

    assign mul_flags = {1'b0, 1'b0, mul_lo[WIDTH-1], ({mul_hi, mul_lo} == '0)};
`endif

    always_comb begin
        state_next = state;
        load_alu   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_start  = 1'b0;
        load_mul   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL_RUN;
                    end else
`endif
                    begin
                        load_alu   = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL_RUN: begin
                if (mul_done) begin
                    load_mul   = 1'b1;
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // Returning to IDLE (not directly accepting) keeps the
                // handshake cycle and the next acceptance distinct.
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            res_reg     <= '0;
            flags_reg   <= '0;
            illegal_reg <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            res_hi_reg  <= '0;
`endif
        end else begin
            state <= state_next;
            if (load_alu) begin
                res_reg     <= alu_res;
                flags_reg   <= alu_flags;
                illegal_reg <= alu_illegal;
`ifdef ALU_SEQ_MUL_EN
                res_hi_reg  <= '0;
            end else if (load_mul) begin
                res_reg     <= mul_lo;
                res_hi_reg  <= mul_hi;
                flags_reg   <= mul_flags;
                illegal_reg <= 1'b0;
`endif
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = res_reg;
`ifdef ALU_SEQ_MUL_EN
    assign result_hi = res_hi_reg;
`else
    assign result_hi = '0;
`endif
    assign cr        = flags_reg.cr;
    assign ov        = flags_reg.ov;
    assign ng        = flags_reg.ng;
    assign zr        = flags_reg.zr;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes the reference model's
// expectation when a request is accepted; an independent monitor compares the
// DUT outputs against the queue head every cycle out_valid is high.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [W-1:0]  ina = '0;
    logic [W-1:0]  inb = '0;
    logic [SW-1:0] shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          cr, ov, ng, zr, illegal;

    alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ina       (ina),
        .inb       (inb),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cr        (cr),
        .ov        (ov),
        .ng        (ng),
        .zr        (zr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   fl;   // {cr, ov, ng, zr, illegal}
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SW-1:0] s);
        exp_t   e;
        longint ua, ub, sa, sb, mask, smax, smin, r, hi, v;
        int     n, k;
        logic   c_m, o_m, ill;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        mask = (longint'(1) << W) - 1;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -smax - 1;
        n    = int'(s);
        r = 0; hi = 0; c_m = 1'b0; o_m = 1'b0; ill = 1'b0;
        e.lat = 1;
        case (o)
            4'h0: r = ua & ub;
            4'h1: r = ua | ub;
            4'h2: begin
                v = ua + ub; r = v & mask; c_m = (v > mask);
                v = sa + sb; o_m = (v > smax) || (v < smin);
            end
            4'h6: begin
                r = (ua - ub) & mask; c_m = (ua >= ub);
                v = sa - sb; o_m = (v > smax) || (v < smin);
            end
            4'h3: r = (n >= W) ? 0 : ((ua << n) & mask);
            4'h4: r = (sa >>> n) & mask;
            4'h5: r = ua >> n;
            4'h7: r = (ua < ub) ? 1 : 0;
            4'h8: begin k = n % W; r = ((ua >> k) | (ua << (W - k))) & mask; end
            4'h9: begin k = n % W; r = ((ua << k) | (ua >> (W - k))) & mask; end
            4'hA: begin
`ifdef ALU_SEQ_MUL_EN
                v = ua * ub; r = v & mask; hi = (v >> W) & mask; e.lat = W + 1;
`else
                ill = 1'b1;
`endif
            end
            4'hF: r = (~ua) & mask;
            default: ill = 1'b1;
        endcase
        e.op  = o;
        e.res = W'(r);
        e.hi  = W'(hi);
        e.fl  = {c_m, o_m, e.res[W-1], (r == 0 && hi == 0), ill};
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compares every valid cycle against the head entry, so held
    // outputs under back-pressure are checked too.
    bit seen = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!out_valid) begin
                seen = 1'b0;
            end else if (q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                end
                check("outputs", 64'({result, result_hi, cr, ov, ng, zr, illegal}),
                      64'({q[0].res, q[0].hi, q[0].fl}));
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    $display("txn op=%b result=%h hi=%h cr/ov/ng/zr/ill=%b lat=%0d",
                             q[0].op, result, result_hi, {cr, ov, ng, zr, illegal}, q[0].lat);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SW-1:0] s);
        exp_t e;
        int   guard;
        in_valid = 1'b1; op = o; ina = a; inb = b; shamt = s;
        guard = 0;
        while (!in_ready && guard < 200) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e     = model(o, a, b, s);
        e.acc = cyc;
        q.push_back(e);
        in_valid = 1'b0;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result_hi", 64'(result_hi), 64'd0);
        check("rst_flags", 64'({cr, ov, ng, zr, illegal}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        out_ready = 1'b1;
        do_op(OP_ADD, 8'h7F, 8'h01, 5'd0);
        do_op(OP_SUB, 8'h05, 8'h05, 5'd0);
        do_op(OP_SUB, 8'h00, 8'h01, 5'd0);
        do_op(OP_MUL, 8'hFF, 8'hFF, 5'd0);
        do_op(OP_RRO, 8'h81, 8'h00, 5'd1);
        do_op(OP_RRO, 8'h81, 8'h00, 5'd9);
        do_op(OP_SRS, 8'h80, 8'h00, 5'd12);
        do_op(OP_URS, 8'h80, 8'h00, 5'd12);
        do_op(OP_LRO, 8'h81, 8'h00, 5'd1);
        do_op(OP_LS,  8'h81, 8'h00, 5'd3);
        do_op(OP_SLT, 8'h03, 8'hF0, 5'd0);
        do_op(OP_SLT, 8'hF0, 8'h03, 5'd0);
        do_op(OP_NOT, 8'h5A, 8'h00, 5'd0);
        do_op(4'b1100, 8'h12, 8'h34, 5'd0);
        drain();

        // Back-pressure: outputs held, in_ready low, new request ignored
        out_ready = 1'b0;
        do_op(OP_ADD, 8'h40, 8'h40, 5'd0);
        in_valid = 1'b1; op = OP_AND; ina = 8'hFF; inb = 8'h0F; shamt = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        do_op(OP_AND, 8'hFF, 8'h0F, 5'd0);
        drain();

        // Reset in the fourth cycle after a MUL is accepted
        out_ready = 1'b0;
        do_op(OP_MUL, 8'h12, 8'h34, 5'd0);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_outputs", 64'({result, result_hi, cr, ov, ng, zr, illegal}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_op(4'b1011, 8'h03, 8'h04, 5'd0);
        drain();

        // Randomised operations with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            do_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                  SW'($urandom_range(0, 31)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
